// File: rtl/apb4_ram_pkg.sv
// Shared types and helpers for the parametrised APB4 scratch RAM.
package apb4_ram_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Number of byte-offset address bits for a given data width.
  function automatic int boff(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb4_ram_mem.sv
// Single-port byte-enabled word array with a registered read port.
module apb4_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              pclk,
  input  logic              we,
  input  logic              re,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [NB-1:0][7:0] mem_q [DEPTH];
  logic [DATA_W-1:0]  rdata_d, rdata_q;

  // Read register holds zero unless a read is performed, so it can drive the bus directly.
  always_comb begin
    rdata_d = '0;
    if (re) rdata_d = mem_q[idx];
  end

  always_ff @(posedge pclk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][b] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb4_ram_slave.sv
// APB4 slave RAM: byte strobes, programmable read/write wait states, pslverr on bad addresses.
module apb4_ram_slave
  import apb4_ram_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int WAIT_WR = 0,
  parameter int WAIT_RD = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int NB    = DATA_W / 8;
  localparam int BOFF  = boff(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BOFF) - 1);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb4_ram_slave: DATA_W must be 8, 16, 32 or 64");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << (ADDR_W - BOFF))) begin : g_bad_depth
    $error("apb4_ram_slave: DEPTH does not fit in the word address space");
  end
  if (WAIT_WR < 0 || WAIT_WR > 15 || WAIT_RD < 0 || WAIT_RD > 15) begin : g_bad_wait
    $error("apb4_ram_slave: WAIT_WR/WAIT_RD must be in 0..15");
  end

  state_e                  state_d, state_q;
  logic [WAIT_CNT_W-1:0]   cnt_d, cnt_q;
  logic                    pready_d, pready_q;
  logic                    pslverr_d, pslverr_q;

  logic                    write_d, write_q;
  logic [ADDR_W-1:0]       addr_d, addr_q;
  logic [DATA_W-1:0]       wdata_d, wdata_q;
  logic [NB-1:0]           strb_d, strb_q;

  logic [WAIT_CNT_W-1:0]   wsel;
  logic                    do_acc;
  logic                    acc_write, acc_err;
  logic [ADDR_W-1:0]       acc_addr;
  logic [DATA_W-1:0]       acc_wdata;
  logic [NB-1:0]           acc_strb;
  logic                    mem_we, mem_re;
  logic [DATA_W-1:0]       mem_rdata;

  assign wsel = pwrite ? WAIT_CNT_W'(WAIT_WR) : WAIT_CNT_W'(WAIT_RD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    do_acc    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_strb  = strb_q;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          write_d   = pwrite;
          addr_d    = paddr;
          wdata_d   = pwdata;
          strb_d    = pstrb;
          // A zero-wait access is performed on the setup edge, straight from the bus.
          acc_write = pwrite;
          acc_addr  = paddr;
          acc_wdata = pwdata;
          acc_strb  = pstrb;
          if (wsel == '0) begin
            state_d = ST_RESP;
            do_acc  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wsel - WAIT_CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
          do_acc  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    acc_err   = (|(acc_addr & ALIGN_MASK)) || (64'(acc_addr >> BOFF) >= 64'(DEPTH));
    pready_d  = do_acc;
    pslverr_d = do_acc && acc_err;
    // Reset must suppress the memory access on the same edge so no partial write lands.
    mem_we    = presetn && do_acc && acc_write && !acc_err;
    mem_re    = presetn && do_acc && !acc_write && !acc_err;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_ff @(posedge pclk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

  apb4_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .pclk  (pclk),
    .we    (mem_we),
    .re    (mem_re),
    .be    (acc_strb),
    .idx   (acc_addr[BOFF +: IDX_W]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign prdata  = mem_rdata;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_ram_slave.sv
// Directed bench for apb4_ram_slave: one zero-wait and one wait-state instance against a word-level model.
module tb_apb4_ram_slave;

  localparam int AW = 8, DW = 32, NB = 4, DEPTH = 32;

  logic          pclk = 1'b0, presetn = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [NB-1:0] pstrb = '0;
  int            dsel = 0;

  logic          psel0, psel1;
  logic [DW-1:0] prdata0, prdata1;
  logic          pready0, pready1, pslverr0, pslverr1;

  assign psel0 = psel && (dsel == 0);
  assign psel1 = psel && (dsel == 1);

  always #5 pclk = ~pclk;

  apb4_ram_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_WR(0), .WAIT_RD(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb4_ram_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_WR(3), .WAIT_RD(2)) u_dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  int n_chk = 0, n_fail = 0;

  // Word-level model of each instance's memory.
  logic [DW-1:0] mdl [2][DEPTH];

  bit            chk_en = 0, cur_active = 0, cur_write = 0, cur_err = 0;
  int            cur_acc = 0, cur_w = 0;
  logic [DW-1:0] cur_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [AW-1:0] a);
    return (int'(a) % NB != 0) || (int'(a) / NB >= DEPTH);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Every cycle: the addressed instance must show pready exactly in access cycle W+1, the other stays quiet.
  logic [33:0] exp_vec, act_sel, act_oth;
  bit          exp_rdy;
  always @(negedge pclk) begin
    if (chk_en) begin
      exp_rdy = cur_active && (cur_acc == cur_w + 1);
      exp_vec = {exp_rdy, exp_rdy && cur_err,
                 (exp_rdy && !cur_write && !cur_err) ? cur_rdata : {DW{1'b0}}};
      act_sel = (dsel == 0) ? {pready0, pslverr0, prdata0} : {pready1, pslverr1, prdata1};
      act_oth = (dsel == 0) ? {pready1, pslverr1, prdata1} : {pready0, pslverr0, prdata0};
      check("bus_selected", 64'(act_sel), 64'(exp_vec));
      check("bus_unselected", 64'(act_oth), 64'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the next free cycle so calls chain back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [NB-1:0] st, input int abort_at, input int rst_at,
                      output logic [DW-1:0] rd, output bit err, output int lat);
    dsel = d;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    cur_write = wr;
    cur_err   = addr_err(a);
    cur_w     = (d == 0) ? 0 : (wr ? 3 : 2);
    cur_rdata = cur_err ? '0 : mdl[d][int'(a) / NB];
    cur_acc   = 0;
    cur_active = 1;
    rd = '0; err = 0; lat = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    cur_acc = 1;
    forever begin
      if (abort_at != 0 && cur_acc == abort_at) begin
        psel = 1'b0; penable = 1'b0; cur_active = 0;
        @(posedge pclk); #1;
        break;
      end
      if (rst_at != 0 && cur_acc == rst_at) begin
        presetn = 1'b0; cur_active = 0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        // Bus stays in access phase: a freshly reset slave must not answer it.
        repeat (4) begin @(posedge pclk); #1; end
        psel = 1'b0; penable = 1'b0;
        break;
      end
      @(negedge pclk);
      if (((d == 0) ? pready0 : pready1) === 1'b1) begin
        lat = cur_acc;
        rd  = (d == 0) ? prdata0 : prdata1;
        err = (d == 0) ? pslverr0 : pslverr1;
        if (wr && !cur_err) mdl[d][int'(a) / NB] = merge(mdl[d][int'(a) / NB], wd, st);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; cur_active = 0;
        break;
      end
      if (cur_acc >= 20) begin
        n_chk++; n_fail++;
        $display("FAIL pready_timeout: no pready after %0d access cycles, required by cycle %0d", cur_acc, cur_w + 1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; cur_active = 0;
        break;
      end
      @(posedge pclk); #1;
      cur_acc++;
    end
  endtask

  logic [DW-1:0] rd;
  bit            er;
  int            lat, ndone;
  logic [AW-1:0] ra;

  initial begin
    @(posedge pclk); #1;
    chk_en = 1;
    @(negedge pclk);
    check("reset_state", 64'({pready0, pslverr0, prdata0}), 64'd0);
    check("reset_state_w", 64'({pready1, pslverr1, prdata1}), 64'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Give every word a defined value in both instances.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        xfer(d, 1, AW'(i * NB), $urandom, 4'hF, 0, 0, rd, er, lat);

    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
    check("zw_write_lat", 64'(lat), 64'd1);
    check("zw_write_err", 64'(er), 64'd0);
    xfer(0, 0, 8'h10, '0, 4'h0, 0, 0, rd, er, lat);
    check("zw_read_data", 64'(rd), 64'hDEADBEEF);
    check("zw_read_lat", 64'(lat), 64'd1);

    xfer(0, 1, 8'h20, 32'h11223344, 4'hF, 0, 0, rd, er, lat);
    xfer(0, 1, 8'h20, 32'hAABBCCDD, 4'h5, 0, 0, rd, er, lat);
    check("model_strb", 64'(mdl[0][8]), 64'h11BB33DD);
    xfer(0, 0, 8'h20, '0, 4'h0, 0, 0, rd, er, lat);
    check("strb_read", 64'(rd), 64'h11BB33DD);
    xfer(0, 1, 8'h24, 32'h99999999, 4'h0, 0, 0, rd, er, lat);
    check("strb_zero_err", 64'(er), 64'd0);

    xfer(1, 0, 8'h10, '0, 4'h0, 0, 0, rd, er, lat);
    check("ws_read_lat", 64'(lat), 64'd3);
    xfer(1, 1, 8'h14, 32'h01020304, 4'hF, 0, 0, rd, er, lat);
    check("ws_write_lat", 64'(lat), 64'd4);
    xfer(1, 0, 8'h14, '0, 4'h0, 0, 0, rd, er, lat);
    check("ws_read_back", 64'(rd), 64'h01020304);

    xfer(0, 1, 8'h00, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lat);
    xfer(0, 1, 8'h80, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
    check("oor_write_err", 64'(er), 64'd1);
    xfer(0, 0, 8'h00, '0, 4'h0, 0, 0, rd, er, lat);
    check("oor_mem_intact", 64'(rd), 64'h0BADF00D);
    xfer(0, 0, 8'h13, '0, 4'h0, 0, 0, rd, er, lat);
    check("unaligned_err", 64'(er), 64'd1);
    check("unaligned_data", 64'(rd), 64'd0);
    xfer(1, 1, 8'h81, 32'h0, 4'hF, 0, 0, rd, er, lat);
    check("ws_err_lat", 64'(lat), 64'd4);
    check("ws_err", 64'(er), 64'd1);

    xfer(1, 1, 8'h04, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
    xfer(1, 1, 8'h04, 32'h00000055, 4'hF, 0, 2, rd, er, lat);
    check("rst_no_pready", 64'(lat), 64'd0);
    xfer(1, 0, 8'h04, '0, 4'h0, 0, 0, rd, er, lat);
    check("rst_mem_intact", 64'(rd), 64'hCAFEF00D);

    xfer(1, 1, 8'h08, 32'h12345678, 4'hF, 0, 0, rd, er, lat);
    xfer(1, 1, 8'h08, 32'h00000000, 4'hF, 2, 0, rd, er, lat);
    check("abort_no_pready", 64'(lat), 64'd0);
    xfer(1, 0, 8'h08, '0, 4'h0, 0, 0, rd, er, lat);
    check("abort_mem_intact", 64'(rd), 64'h12345678);

    // Access phase with no setup phase before it: no response expected.
    dsel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C;
    repeat (3) begin @(posedge pclk); #1; end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    for (int d = 0; d < 2; d++) begin
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
        ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, DEPTH - 1) * NB);
        xfer(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 0, 0, rd, er, lat);
        if (lat != 0) ndone++;
      end
      check(d == 0 ? "b2b_count_zw" : "b2b_count_ws", 64'(ndone), 64'd30);
    end

    repeat (2) @(posedge pclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
